// File: rtl/imem_boot_loader.sv
// Byte-serial instruction memory loader: parses A5/LEN/payload/checksum frames and holds the CPU in reset until a good load.
// Optional inter-byte timeout is enabled by defining LOADER_TIMEOUT_EN.
module imem_boot_loader #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0]  SYNC    = 8'hA5;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state, state_nxt;
    logic [1:0]  code_nxt;
    logic        accept;
    logic [15:0] len, len_full;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;
    logic [7:0]  csum;

`ifdef LOADER_TIMEOUT_EN
    localparam int              TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    logic [TMR_W-1:0] tmr;
    logic             mid;
    assign mid = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_DATA)   || (state == S_CSUM);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_nxt = state;
        code_nxt  = err_code;
        rx_ready  = (state != S_DONE);
        done      = (state == S_DONE);
        err       = (state == S_ERR);
        cpu_rst   = (state != S_DONE);
        accept    = rx_valid && rx_ready;
        len_full  = {len[15:8], rx_data};
        case (state)
            S_IDLE:   if (accept && rx_data == SYNC) state_nxt = S_LEN_HI;
            S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: if (accept) begin
                if ({1'b0, len_full} > DEPTH_L) begin
                    state_nxt = S_ERR;
                    code_nxt  = 2'b01;
                end else if (len_full == 16'd0) begin
                    state_nxt = S_CSUM;
                end else begin
                    state_nxt = S_DATA;
                end
            end
            // Last byte of the final word hands off to the checksum byte
            S_DATA:   if (accept && byte_cnt == 2'd3 && 16'(word_idx + 16'd1) == len)
                          state_nxt = S_CSUM;
            S_CSUM:   if (accept) begin
                if (rx_data == csum) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ERR;
                    code_nxt  = 2'b10;
                end
            end
            S_ERR:    if (accept && rx_data == SYNC) begin
                state_nxt = S_LEN_HI;
                code_nxt  = 2'b00;
            end
            default:  state_nxt = state;
        endcase
`ifdef LOADER_TIMEOUT_EN
        if (mid && !accept && tmr == TMR_LAST) begin
            state_nxt = S_ERR;
            code_nxt  = 2'b11;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            err_code  <= 2'b00;
            len       <= 16'd0;
            word_idx  <= 16'd0;
            byte_cnt  <= 2'd0;
            asm_q     <= 24'd0;
            csum      <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            state    <= state_nxt;
            err_code <= code_nxt;
            mem_we   <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE, S_ERR: if (rx_data == SYNC) begin
                        word_idx <= 16'd0;
                        byte_cnt <= 2'd0;
                        csum     <= 8'd0;
                    end
                    S_LEN_HI: len[15:8] <= rx_data;
                    S_LEN_LO: len <= len_full;
                    S_DATA: begin
                        asm_q    <= {asm_q[15:0], rx_data};
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx[ADDR_W-1:0];
                            mem_wdata <= {asm_q, rx_data};
                            word_idx  <= word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Idle gap counter; only runs while a frame is partially received
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (accept) begin
            tmr <= '0;
        end else if (mid) begin
            tmr <= tmr + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: frames are built from word lists, expected writes queued, a monitor checks every strobe.
module tb_imem_boot_loader;

    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .done(done), .err(err), .err_code(err_code)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         sb[$];
    wr_t         mon_e;
    logic [31:0] words[$];
    int          tests = 0;
    int          fails = 0;
    logic        prev_we = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (rst) begin
            if (mem_we) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr, mem_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check_output("wr_data", mem_wdata, mon_e.data);
                end
                if (prev_we) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL we_pulse: got 2-cycle strobe expected 1-cycle");
                end
            end
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL rx_ready_wait: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom());
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
        end
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    // Builds a frame from the word list, queues the writes it should cause and predicts the outcome
    task automatic apply_stimulus(input int n, input logic [7:0] csum_xor, input int gap_max,
                                  output bit exp_done, output bit exp_err, output logic [1:0] exp_code);
        logic [7:0]  bytes[$];
        logic [7:0]  cs;
        logic [15:0] n16;
        logic [31:0] w;
        wr_t         e;
        cs  = 8'd0;
        n16 = 16'(n);
        bytes.push_back(8'hA5);
        bytes.push_back(n16[15:8]);
        bytes.push_back(n16[7:0]);
        if (n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_code = 2'b01;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = words[i];
                for (int k = 3; k >= 0; k--) begin
                    bytes.push_back(w[k*8 +: 8]);
                    cs = cs ^ w[k*8 +: 8];
                end
                e.addr = ADDR_W'(i);
                e.data = w;
                sb.push_back(e);
            end
            bytes.push_back(cs ^ csum_xor);
            exp_done = (csum_xor == 8'd0);
            exp_err  = (csum_xor != 8'd0);
            exp_code = (csum_xor != 8'd0) ? 2'b10 : 2'b00;
        end
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic check_state(input string name, input bit d, input bit e, input logic [1:0] c);
        idle(3);
        check_output({name, "_done"}, 32'(done), 32'(d));
        check_output({name, "_err"}, 32'(err), 32'(e));
        check_output({name, "_code"}, 32'(err_code), 32'(c));
        check_output({name, "_cpu_rst"}, 32'(cpu_rst), 32'(!d));
        check_output({name, "_rx_ready"}, 32'(rx_ready), 32'(!d));
        check_output({name, "_pending"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_output("rst_rx_ready", 32'(rx_ready), 32'd1);
        check_output("rst_mem_we", 32'(mem_we), 32'd0);
        check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_output("rst_mem_wdata", mem_wdata, 32'd0);
        check_output("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_err_code", 32'(err_code), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         ed, ee;
        logic [1:0] ec;
        int         n, n2;
        logic [7:0] csx;

        do_reset();

        words = '{32'h24010005, 32'h8C020004};
        apply_stimulus(2, 8'h00, 0, ed, ee, ec);
        check_state("frame_a", ed, ee, ec);

        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        words.delete();
        apply_stimulus(0, 8'h00, 0, ed, ee, ec);
        check_state("garbage_n0", ed, ee, ec);

        do_reset();
        words = '{32'h11223344};
        apply_stimulus(1, 8'h44, 0, ed, ee, ec);
        check_state("bad_csum", ed, ee, ec);
        fill_words(3);
        apply_stimulus(3, 8'h00, 1, ed, ee, ec);
        check_state("resync", ed, ee, ec);

        do_reset();
        apply_stimulus(257, 8'h00, 0, ed, ee, ec);
        check_state("overflow", ed, ee, ec);

        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        fill_words(1);
        apply_stimulus(1, 8'h00, 0, ed, ee, ec);
        check_state("abort_resend", ed, ee, ec);

        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
`ifdef LOADER_TIMEOUT_EN
        idle(TIMEOUT - 1);
        check_output("timeout_early_err", 32'(err), 32'd0);
        idle(1);
        check_output("timeout_err", 32'(err), 32'd1);
        check_output("timeout_code", 32'(err_code), 32'd3);
        check_output("timeout_cpu_rst", 32'(cpu_rst), 32'd1);
`else
        idle(1100);
        check_output("wait_err", 32'(err), 32'd0);
        check_output("wait_code", 32'(err_code), 32'd0);
        check_output("wait_done", 32'(done), 32'd0);
        check_output("wait_cpu_rst", 32'(cpu_rst), 32'd1);
        check_output("wait_rx_ready", 32'(rx_ready), 32'd1);
`endif

        for (int it = 0; it < 24; it++) begin
            do_reset();
            send_garbage($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) n = DEPTH + 1 + $urandom_range(0, 500);
            else n = $urandom_range(0, 6);
            csx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            fill_words((n <= DEPTH) ? n : 0);
            apply_stimulus(n, csx, 2, ed, ee, ec);
            check_state("rand", ed, ee, ec);
            if (ee && $urandom_range(0, 1) == 1) begin
                n2 = $urandom_range(1, 5);
                fill_words(n2);
                apply_stimulus(n2, 8'h00, 1, ed, ee, ec);
                check_state("rand_retry", ed, ee, ec);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
